// File: rtl/hpdmc_cmdseq.sv
// hpdmc_cmdseq: SDRAM command sequencer for HPDMC normal operation.
// Turns one-at-a-time word requests into PRECHARGE / ACTIVATE / READ / WRITE
// sequences with an open-page policy, and inserts periodic AUTO REFRESH.
module hpdmc_cmdseq #(
    parameter int sdram_depth       = 24,
    parameter int sdram_columndepth = 9
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   enable,
    input  logic [2:0]             tim_rp,
    input  logic [2:0]             tim_rcd,
    input  logic [10:0]            tim_refi,
    input  logic [3:0]             tim_rfc,
    input  logic                   cmd_stb,
    input  logic                   cmd_we,
    input  logic [sdram_depth-1:0] cmd_adr,
    output logic                   cmd_ack,
    input  logic                   dp_busy,
    output logic                   read_issue,
    output logic                   write_issue,
    output logic                   sdram_cs_n,
    output logic                   sdram_ras_n,
    output logic                   sdram_cas_n,
    output logic                   sdram_we_n,
    output logic [12:0]            sdram_adr,
    output logic [1:0]             sdram_ba
);

    localparam int ROW_W = sdram_depth - sdram_columndepth - 2;

    // State names the command most recently placed on the pins.
    typedef enum logic [2:0] {
        S_IDLE, S_PRECHARGE, S_ACTIVATE, S_RW, S_PREALL, S_REFRESH
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ACT, C_READ, C_WRITE, C_PRE, C_PREALL, C_REF
    } cmd_t;

    // {cs_n, ras_n, cas_n, we_n} for each command
    function automatic logic [3:0] pins_of(input cmd_t c);
        case (c)
            C_ACT:            return 4'b0011;
            C_READ:           return 4'b0101;
            C_WRITE:          return 4'b0100;
            C_PRE, C_PREALL:  return 4'b0010;
            C_REF:            return 4'b0001;
            default:          return 4'b1111;
        endcase
    endfunction

    state_t                       r_state, w_state_next;
    cmd_t                         w_cmd;
    logic [12:0]                  w_adr, r_adr;
    logic [1:0]                   w_ba, r_ba;
    logic [3:0]                   r_pins;
    logic                         r_ack, r_rd, r_wr;
    logic [3:0]                   r_wait;
    logic [10:0]                  r_refcnt;
    logic                         r_ref_pending;
    logic [3:0]                   r_open;
    logic [ROW_W-1:0]             r_row [4];

    logic [ROW_W-1:0]             w_row;
    logic [1:0]                   w_bank;
    logic [sdram_columndepth-1:0] w_col;
    logic                         w_hit, w_ready, w_any_open;

    assign w_row      = cmd_adr[sdram_depth-1 -: ROW_W];
    assign w_bank     = cmd_adr[sdram_columndepth +: 2];
    assign w_col      = cmd_adr[sdram_columndepth-1:0];
    assign w_hit      = r_open[w_bank] && (r_row[w_bank] == w_row);
    assign w_any_open = |r_open;
    // The counter holds tim_x during the command cycle, so <=1 here puts the
    // next command exactly max(tim_x,1) cycles after the previous one.
    assign w_ready    = !dp_busy && (r_wait <= 4'd1);

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_pins;
    assign sdram_adr   = r_adr;
    assign sdram_ba    = r_ba;
    assign cmd_ack     = r_ack;
    assign read_issue  = r_rd;
    assign write_issue = r_wr;

    // State register
    always_ff @(posedge sys_clk) begin
        // NOTE: registers take <= so every flop samples pre-edge values; = here would create order-dependent races.
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next state follows the command chosen this cycle
    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned, which would infer a latch.
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (w_cmd)
                C_PRE:            w_state_next = S_PRECHARGE;
                C_PREALL:         w_state_next = S_PREALL;
                C_ACT:            w_state_next = S_ACTIVATE;
                C_READ, C_WRITE:  w_state_next = S_RW;
                C_REF:            w_state_next = S_REFRESH;
                default: if (r_state == S_RW || r_state == S_REFRESH) w_state_next = S_IDLE;
            endcase
        end
    end

    // Command selection and its address/bank for this cycle
    always_comb begin
        w_cmd = C_NOP;
        w_adr = r_adr;
        w_ba  = r_ba;
        if (enable && w_ready) begin
            unique case (r_state)
                S_IDLE, S_REFRESH, S_RW: begin
                    if (r_ref_pending) begin
                        w_cmd = w_any_open ? C_PREALL : C_REF;
                    end else if (cmd_stb && r_state != S_RW) begin
                        // The requester still holds cmd_stb during the ack
                        // cycle, so a request is never accepted in S_RW.
                        if (w_hit)               w_cmd = cmd_we ? C_WRITE : C_READ;
                        else if (r_open[w_bank]) w_cmd = C_PRE;
                        else                     w_cmd = C_ACT;
                    end
                end
                S_PRECHARGE: w_cmd = C_ACT;
                S_ACTIVATE:  w_cmd = cmd_we ? C_WRITE : C_READ;
                S_PREALL:    w_cmd = C_REF;
                default:     w_cmd = C_NOP;
            endcase
        end
        case (w_cmd)
            C_ACT:           begin w_adr = 13'(w_row); w_ba = w_bank; end
            C_READ, C_WRITE: begin w_adr = 13'(w_col); w_ba = w_bank; end
            C_PRE:           begin w_adr = '0;         w_ba = w_bank; end
            C_PREALL:        w_adr = 13'h400;
            default:         ;
        endcase
    end

    // Registered pins and handshake pulses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pins <= 4'b1111;
            r_adr  <= '0;
            r_ba   <= '0;
            r_ack  <= 1'b0;
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
        end else begin
            r_pins <= pins_of(w_cmd);
            r_adr  <= w_adr;
            r_ba   <= w_ba;
            r_ack  <= (w_cmd == C_READ) || (w_cmd == C_WRITE);
            r_rd   <= (w_cmd == C_READ);
            r_wr   <= (w_cmd == C_WRITE);
        end
    end

    // Inter-command wait counter; keeps running regardless of enable/dp_busy
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                              r_wait <= '0;
        else if (w_cmd == C_ACT)                  r_wait <= {1'b0, tim_rcd};
        else if (w_cmd == C_PRE || w_cmd == C_PREALL) r_wait <= {1'b0, tim_rp};
        else if (w_cmd == C_REF)                  r_wait <= tim_rfc;
        else if (r_wait != 4'd0)                  r_wait <= r_wait - 4'd1;
    end

    // Refresh interval counter; an expiry in the REF cycle keeps the request
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !enable) begin
            r_refcnt      <= tim_refi;
            r_ref_pending <= 1'b0;
        end else begin
            if (w_cmd == C_REF) r_ref_pending <= 1'b0;
            if (r_refcnt == 11'd0) begin
                r_refcnt      <= tim_refi;
                r_ref_pending <= 1'b1;
            end else begin
                r_refcnt <= r_refcnt - 11'd1;
            end
        end
    end

    // Open-bank flags; losing ownership of the SDRAM forgets every open row
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !enable) begin
            r_open <= '0;
        end else begin
            case (w_cmd)
                C_PREALL: r_open         <= '0;
                C_PRE:    r_open[w_bank] <= 1'b0;
                C_ACT:    r_open[w_bank] <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Open-row storage per bank
    always_ff @(posedge sys_clk) begin
        // NOTE: no reset on this storage; a row is only ever read while its r_open flag (which is reset) is set.
        if (w_cmd == C_ACT) r_row[w_bank] <= w_row;
    end

endmodule

// File: tb/tb_hpdmc_cmdseq.sv
// tb_hpdmc_cmdseq: randomized bench for hpdmc_cmdseq against a queue-based
// command-plan model with absolute-time command spacing.
module tb_hpdmc_cmdseq;

    logic        sys_clk = 1'b0;
    logic        sys_rst, enable, cmd_stb, cmd_we, dp_busy;
    logic [2:0]  tim_rp, tim_rcd;
    logic [10:0] tim_refi;
    logic [3:0]  tim_rfc;
    logic [23:0] cmd_adr;
    logic        cmd_ack, read_issue, write_issue;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [12:0] sdram_adr;
    logic [1:0]  sdram_ba;

    hpdmc_cmdseq dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .tim_rp(tim_rp), .tim_rcd(tim_rcd), .tim_refi(tim_refi), .tim_rfc(tim_rfc),
        .cmd_stb(cmd_stb), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_ack(cmd_ack),
        .dp_busy(dp_busy), .read_issue(read_issue), .write_issue(write_issue),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_adr(sdram_adr), .sdram_ba(sdram_ba)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_PRE, K_PREALL, K_ACT, K_RW, K_REF} kind_e;
    typedef struct {
        kind_e kind;
        int    bank;
        int    row;
        int    col;
        bit    we;
    } mcmd_t;

    mcmd_t    plan[$];
    int       m_cyc = 0;        // pin cycle being produced by the current edge
    int       m_earliest = 0;   // first pin cycle a new command may use
    int       m_rw_block = -1;  // pin cycle in which no new request may start
    bit [3:0] m_open;
    int       m_row[4];
    bit       m_pend;
    int       m_ref;

    logic [3:0]  e_pins = 4'b1111;
    logic [12:0] e_adr = '0, e_adr_mask = 13'h1fff;
    logic [1:0]  e_ba = '0;
    bit          e_ba_known = 1'b1;
    bit          e_ack, e_rd, e_wr;

    function automatic int mx1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic void push(input kind_e k, input int b, input int r, input int c, input bit w);
        mcmd_t m;
        m.kind = k; m.bank = b; m.row = r; m.col = c; m.we = w;
        plan.push_back(m);
    endfunction

    // Work out the full command list for the next job
    function automatic void plan_next();
        int r, b, c;
        if (m_pend) begin
            if (m_open != 4'd0) push(K_PREALL, 0, 0, 0, 1'b0);
            push(K_REF, 0, 0, 0, 1'b0);
        end else if (cmd_stb && m_cyc != m_rw_block) begin
            r = int'(cmd_adr[23:11]);
            b = int'(cmd_adr[10:9]);
            c = int'(cmd_adr[8:0]);
            if (!(m_open[b] && m_row[b] == r)) begin
                if (m_open[b]) push(K_PRE, b, r, c, cmd_we);
                push(K_ACT, b, r, c, cmd_we);
            end
            push(K_RW, b, r, c, cmd_we);
        end
    endfunction

    function automatic void issue(input mcmd_t c);
        case (c.kind)
            K_PRE: begin
                e_pins = 4'b0010; e_adr = '0; e_adr_mask = 13'h400;
                e_ba = 2'(c.bank); e_ba_known = 1'b1;
                m_open[c.bank] = 1'b0;
                m_earliest = m_cyc + mx1(int'(tim_rp));
            end
            K_PREALL: begin
                e_pins = 4'b0010; e_adr = 13'h400; e_adr_mask = 13'h400;
                e_ba_known = 1'b0;
                m_open = '0;
                m_earliest = m_cyc + mx1(int'(tim_rp));
            end
            K_ACT: begin
                e_pins = 4'b0011; e_adr = 13'(c.row); e_adr_mask = 13'h1fff;
                e_ba = 2'(c.bank); e_ba_known = 1'b1;
                m_open[c.bank] = 1'b1; m_row[c.bank] = c.row;
                m_earliest = m_cyc + mx1(int'(tim_rcd));
            end
            K_RW: begin
                e_pins = c.we ? 4'b0100 : 4'b0101;
                e_adr = 13'(c.col); e_adr_mask = 13'h1fff;
                e_ba = 2'(c.bank); e_ba_known = 1'b1;
                e_ack = 1'b1; e_rd = !c.we; e_wr = c.we;
                m_earliest = m_cyc + 1;
                m_rw_block = m_cyc + 1;
            end
            default: begin
                e_pins = 4'b0001;
                m_pend = 1'b0;
                m_earliest = m_cyc + mx1(int'(tim_rfc));
            end
        endcase
    endfunction

    // One clock edge of the model, using the inputs valid before that edge
    function automatic void model_step();
        m_cyc++;
        e_pins = 4'b1111; e_ack = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        if (sys_rst) begin
            plan.delete();
            m_open = '0; m_pend = 1'b0; m_ref = int'(tim_refi);
            m_earliest = 0; m_rw_block = -1;
            e_adr = '0; e_adr_mask = 13'h1fff; e_ba = '0; e_ba_known = 1'b1;
        end else if (!enable) begin
            plan.delete();
            m_open = '0; m_pend = 1'b0; m_ref = int'(tim_refi);
        end else begin
            if (!dp_busy && m_cyc >= m_earliest) begin
                if (plan.size() == 0) plan_next();
                if (plan.size() != 0) issue(plan.pop_front());
            end
            if (m_ref == 0) begin
                m_pend = 1'b1;
                m_ref  = int'(tim_refi);
            end else begin
                m_ref--;
            end
        end
    endfunction

    // ---------------- stimulus ----------------
    int busy_pct = 0;
    int en_drop_pct = 0;
    localparam int ACK_LIMIT = 400;

    task automatic compare_outputs();
        check("pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, e_pins);
        check("cmd_ack", cmd_ack, e_ack);
        check("read_issue", read_issue, e_rd);
        check("write_issue", write_issue, e_wr);
        check("sdram_adr", sdram_adr & e_adr_mask, e_adr & e_adr_mask);
        if (e_ba_known) check("sdram_ba", sdram_ba, e_ba);
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        compare_outputs();
        if (busy_pct > 0)    dp_busy = ($urandom_range(99) < busy_pct);
        if (en_drop_pct > 0) enable  = ($urandom_range(99) >= en_drop_pct);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic logic [23:0] mk(input int row, input int bank, input int col);
        return {13'(row), 2'(bank), 9'(col)};
    endfunction

    task automatic start_req(input logic we, input logic [23:0] adr);
        cmd_stb = 1'b1;
        cmd_we  = we;
        cmd_adr = adr;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            step();
            n++;
        end while (!e_ack && n < ACK_LIMIT);
        check("ack_wait_bound", 32'(n >= ACK_LIMIT), 0);
        cmd_stb = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [23:0] adr);
        start_req(we, adr);
        wait_ack();
    endtask

    // Reload the refresh counter with a new interval
    task automatic set_refi(input int v);
        tim_refi = 11'(v);
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        sys_rst = 1'b1; enable = 1'b1; dp_busy = 1'b0;
        cmd_stb = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
        tim_rp = 3'd2; tim_rcd = 3'd2; tim_rfc = 4'd8; tim_refi = 11'd2047;
        idle(3);
        sys_rst = 1'b0;
        idle(2);

        // Closed bank, same-row hit, then a row miss in the same bank
        do_req(1'b0, mk(5, 1, 'h10));
        idle(2);
        do_req(1'b0, mk(5, 1, 'h11));
        do_req(1'b1, mk(7, 1, 'h20));
        idle(2);

        // Short refresh interval with bank 1 open, a request arriving mid-refresh
        set_refi(20);
        do_req(1'b0, mk(5, 1, 'h30));
        idle(12);
        do_req(1'b0, mk(5, 1, 'h31));
        for (int i = 0; i < 12; i++) begin
            idle(int'($urandom_range(4)));
            do_req(1'($urandom_range(1)), mk(int'($urandom_range(2)), int'($urandom_range(3)), int'($urandom_range(511))));
        end

        // dp_busy held 5 cycles while a request waits in IDLE
        set_refi(2047);
        idle(2);
        dp_busy = 1'b1;
        start_req(1'b0, mk(3, 0, 'h44));
        idle(5);
        dp_busy = 1'b0;
        wait_ack();

        // enable dropped between ACT and READ; request re-runs from ACT
        tim_rcd = 3'd4;
        start_req(1'b0, mk(9, 2, 'h05));
        n = 0;
        do begin
            step();
            n++;
        end while (e_pins != 4'b0011 && n < 50);
        check("act_seen_bound", 32'(n >= 50), 0);
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        wait_ack();
        tim_rcd = 3'd2;

        // Randomized traffic with random timings, busy and enable drops
        busy_pct = 20;
        en_drop_pct = 2;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(9) == 0) begin
                tim_rp   = 3'($urandom_range(7));
                tim_rcd  = 3'($urandom_range(7));
                tim_rfc  = 4'($urandom_range(15));
                tim_refi = 11'($urandom_range(100, 40));
            end
            idle(int'($urandom_range(3)));
            do_req(1'($urandom_range(1)), mk(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(511))));
        end
        busy_pct = 0;
        en_drop_pct = 0;
        enable = 1'b1;
        dp_busy = 1'b0;
        idle(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hpdmc_cmdseq.md
Name: hpdmc_cmdseq

Overview:
SDRAM command sequencer for HPDMC normal (non-bypass) operation. Accepts one-at-a-time word read/write requests and issues the required command sequence to the SDRAM pins: PRECHARGE, ACTIVATE, READ/WRITE and periodic AUTO REFRESH. Tracks the open row in each of the 4 banks (open-page policy) and enforces the tRP/tRCD/tRFC/tREFI timings supplied by the configuration block. Sits between the bus front-end and the data path; the pin mux selects this block when bypass=0.

Parameters:
sdram_depth, 24, request address width (row+bank+column bits)
sdram_columndepth, 9, column bits; row bits = sdram_depth-sdram_columndepth-2 (13 at defaults)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
enable  in  1  high = sequencer owns the SDRAM (tie to ~bypass & ~sdram_rst)
tim_rp  in  3  PRECHARGE-to-next-command clocks
tim_rcd  in  3  ACTIVATE-to-READ/WRITE clocks
tim_refi  in  11  refresh interval clocks
tim_rfc  in  4  AUTO REFRESH-to-next-command clocks
cmd_stb  in  1  request valid; held stable until cmd_ack
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  sdram_depth  {row, bank[1:0], column}
cmd_ack  out  1  one-cycle pulse, asserted with the READ/WRITE command
dp_busy  in  1  data path busy; no command issued while high
read_issue  out  1  pulse when READ is on the pins
write_issue  out  1  pulse when WRITE is on the pins
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  SDRAM command pins
sdram_adr  out  13  SDRAM address
sdram_ba  out  2  SDRAM bank

Behaviour:
- All outputs registered. "Cycle T" = cycle during which a command is on the pins. Non-command cycles: cs_n=ras_n=cas_n=we_n=1; adr/ba hold their last value.
- Encoding (ras_n,cas_n,we_n) with cs_n=0: ACT 011, READ 101, WRITE 100, PRE 010, REF 001.
- Reset: state IDLE, all command pins 1, adr=0, ba=0, cmd_ack/read_issue/write_issue=0, all banks closed, refresh_pending=0, wait counter=0, refresh counter loaded with tim_refi.
- Wait counter: a command at T loads tim_x (rp/rcd/rfc) into the counter; the next command is at earliest T+max(tim_x,1). READ/WRITE load nothing; the next command is at earliest T+1.
- Refresh counter: while enable=0 or sys_rst, hold at tim_refi. Otherwise it decrements every cycle. At 0 it sets refresh_pending and reloads tim_refi. A second expiry while pending is absorbed.
- States: IDLE, PRECHARGE, ACTIVATE, RW, PREALL, REFRESH, plus wait handling via the counter.
- IDLE, no command while dp_busy=1 or wait counter!=0. Priority order:
  - refresh_pending=1: if any bank is open, go to PREALL (PRE with adr[10]=1, all banks marked closed, load tim_rp), then REFRESH; else go straight to REFRESH. REFRESH issues REF, loads tim_rfc, clears refresh_pending and returns to IDLE.
  - cmd_stb=1, bank open with the same row (hit): READ/WRITE on the cycle after cmd_stb is sampled.
  - Bank open with a different row (miss): PRE to that bank (adr[10]=0, load tim_rp), then ACT, then RW.
  - Bank closed: ACT (adr=row, ba=bank, load tim_rcd, mark the row open), then RW.
- RW: READ/WRITE with adr={3'b0 (adr[10]=0, no auto-precharge), column zero-extended}, ba=bank. cmd_ack and read_issue/write_issue are high that cycle only. Return to IDLE.
- Refresh and request becoming eligible in the same cycle: refresh wins. Expiry mid-sequence: the request sequence completes first, then refresh.
- enable falls in any state: next cycle pins deselected, state=IDLE, all banks marked closed, refresh_pending cleared, no ack for the aborted request. Software re-initialises the SDRAM with precharge-all before re-enabling.
- dp_busy high in any state delays the pending command without losing it. Timing counters keep running.

Test Plan:
- Defaults tim_rp=2, tim_rcd=2, tim_rfc=8. Read, closed bank, cmd_adr row=5 ba=1 col=0x10 -> ACT adr=5 ba=1 at T; READ adr=0x010 ba=1 at T+2; cmd_ack=read_issue=1 at T+2 only.
- Repeat the read to row 5 ba 1 col 0x11 -> READ one cycle after cmd_stb, no ACT/PRE.
- Write to row 7 ba 1 (miss) -> PRE ba=1 adr[10]=0 at T; ACT adr=7 at T+2; WRITE at T+4; write_issue=1 at T+4.
- tim_refi=20 with bank 1 open -> on expiry: PRE adr[10]=1 at T, REF at T+2, pins deselected T+3..T+9. A request pending since T is serviced as closed-bank (ACT at T+10).
- Refresh expiry and cmd_stb in the same IDLE cycle -> refresh sequence first, then ACT. dp_busy held high 5 cycles in IDLE -> no command until it drops, then the command issues next cycle.
- enable=0 between ACT and READ -> no READ, no cmd_ack, pins deselected. After re-enable the same request issues ACT (banks closed).
